// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter.
// The arbiter uses the slave modport; the requesters and the RAM model sit on the master side.
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_a;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              done_a;
  logic              done_b;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_rdata,
    input  gnt_a, gnt_b, done_a, done_b, rdata, ram_addr, ram_data, ram_read, ram_write
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, ram_rdata,
    output gnt_a, gnt_b, done_a, done_b, rdata, ram_addr, ram_data, ram_read, ram_write
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single-port RAM: grant, one RAM access cycle,
// then a done pulse. A transaction occupies exactly three cycles.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic          clk,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  logic              last_b;
  logic              owner_b;
  logic              pick_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Winner selection: a lone request wins outright, a tie goes to whoever was not served last.
  always_comb begin
    pick_b   = bus.req_b && (!bus.req_a || !last_b);
    win_we   = pick_b ? bus.we_b    : bus.we_a;
    win_addr = pick_b ? bus.addr_b  : bus.addr_a;
    win_data = pick_b ? bus.wdata_b : bus.wdata_a;
  end

  // The grant acknowledges the request in the same IDLE cycle it is sampled, so it is
  // decoded from the registered state and pointer rather than delayed by a flop.
  assign bus.gnt_a = (state == IDLE) && bus.req_a && !pick_b;
  assign bus.gnt_b = (state == IDLE) && pick_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_b        <= 1'b1;
      owner_b       <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_data  <= '0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      bus.rdata     <= '0;
      bus.done_a    <= 1'b0;
      bus.done_b    <= 1'b0;
    end else begin
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
      bus.done_a    <= 1'b0;
      bus.done_b    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_a || bus.req_b) begin
            state         <= ACCESS;
            owner_b       <= pick_b;
            last_b        <= pick_b;
            bus.ram_addr  <= win_addr;
            bus.ram_data  <= win_data;
            bus.ram_write <= win_we;
            bus.ram_read  <= !win_we;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (bus.ram_read) begin
            bus.rdata <= bus.ram_rdata;
          end
          bus.done_a <= !owner_b;
          bus.done_b <= owner_b;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
